// File: rtl/clock_set_controller_if.sv
// Bundle of the button inputs, running-time inputs and the edit/alarm
// outputs of clock_set_controller.
//   slave  : controller side (buttons and running time in, edit/alarm out)
//   master : driver side (buttons and running time out, edit/alarm in)
interface clock_set_controller_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [6:0] curr_minutes;
  logic [5:0] curr_hours;
  logic [6:0] edit_minutes;
  logic [5:0] edit_hours;
  logic       time_load;
  logic [6:0] alarm_minutes;
  logic [5:0] alarm_hours;
  logic       alarm_load;
  logic [2:0] mode;

  modport slave (
    input  btn_mode, btn_inc, curr_minutes, curr_hours,
    output edit_minutes, edit_hours, time_load,
           alarm_minutes, alarm_hours, alarm_load, mode
  );

  modport master (
    output btn_mode, btn_inc, curr_minutes, curr_hours,
    input  edit_minutes, edit_hours, time_load,
           alarm_minutes, alarm_hours, alarm_load, mode
  );
endinterface

// File: rtl/clock_set_controller.sv
// Time/alarm setting controller. A mode button walks through hour/minute
// edit of the running time (committed with time_load) and then of the alarm
// (committed with alarm_load). The increment button bumps the field being
// edited, once per press and with auto-repeat while held. An edit left idle
// for TIMEOUT_CYCLES is abandoned without any load.
//
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : clock_set_controller_if.slave (buttons, running time, edit/alarm
//          fields, load strobes, mode)
//
// state  | meaning
// IDLE   | running, no edit in progress
// T_HOUR | editing time hours
// T_MIN  | editing time minutes
// A_HOUR | editing alarm hours (edit fields reloaded from alarm on entry)
// A_MIN  | editing alarm minutes
module clock_set_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 500000000,
  parameter int unsigned REPEAT_DELAY   = 25000000,
  parameter int unsigned REPEAT_PERIOD  = 10000000
) (
  input  logic                  clk,
  input  logic                  rst,
  clock_set_controller_if.slave bus
);

  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RPT_W = $clog2(RPT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    T_HOUR = 3'd1,
    T_MIN  = 3'd2,
    A_HOUR = 3'd3,
    A_MIN  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] edit_hr_q, edit_hr_d;
  logic [6:0] edit_min_q, edit_min_d;
  logic [5:0] alarm_hr_q, alarm_hr_d;
  logic [6:0] alarm_min_q, alarm_min_d;
  logic       time_load_q, time_load_d;
  logic       alarm_load_q, alarm_load_d;
  logic       inc_prev_q;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic       in_edit;
  logic       inc_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      edit_hr_q    <= '0;
      edit_min_q   <= '0;
      alarm_hr_q   <= '0;
      alarm_min_q  <= '0;
      time_load_q  <= 1'b0;
      alarm_load_q <= 1'b0;
      inc_prev_q   <= 1'b0;
      to_cnt_q     <= '0;
      rpt_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      edit_hr_q    <= edit_hr_d;
      edit_min_q   <= edit_min_d;
      alarm_hr_q   <= alarm_hr_d;
      alarm_min_q  <= alarm_min_d;
      time_load_q  <= time_load_d;
      alarm_load_q <= alarm_load_d;
      inc_prev_q   <= bus.btn_inc;
      to_cnt_q     <= to_cnt_d;
      rpt_cnt_q    <= rpt_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    edit_hr_d    = edit_hr_q;
    edit_min_d   = edit_min_q;
    alarm_hr_d   = alarm_hr_q;
    alarm_min_d  = alarm_min_q;
    time_load_d  = 1'b0;
    alarm_load_d = 1'b0;
    to_cnt_d     = '0;
    rpt_cnt_d    = '0;
    inc_req      = 1'b0;
    in_edit      = (state_q != IDLE);

    // Press gives one increment and arms the repeat down-counter; terminal
    // count (1) gives another increment and rearms with the repeat period.
    if (in_edit && bus.btn_inc) begin
      if (!inc_prev_q) begin
        inc_req   = 1'b1;
        rpt_cnt_d = RPT_W'(REPEAT_DELAY);
      end else if (rpt_cnt_q == RPT_W'(1)) begin
        inc_req   = 1'b1;
        rpt_cnt_d = RPT_W'(REPEAT_PERIOD);
      end else if (rpt_cnt_q != '0) begin
        rpt_cnt_d = rpt_cnt_q - RPT_W'(1);
      end
    end

    case (state_q)
      IDLE: if (bus.btn_mode) begin
        state_d    = T_HOUR;
        edit_hr_d  = bus.curr_hours;
        edit_min_d = bus.curr_minutes;
      end
      T_HOUR: if (bus.btn_mode) state_d = T_MIN;
      T_MIN: if (bus.btn_mode) begin
        state_d     = A_HOUR;
        time_load_d = 1'b1;
      end
      A_HOUR: if (bus.btn_mode) state_d = A_MIN;
      A_MIN: if (bus.btn_mode) begin
        state_d      = IDLE;
        alarm_hr_d   = edit_hr_q;
        alarm_min_d  = edit_min_q;
        alarm_load_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // edit_* stays at the committed time during the time_load cycle and
    // switches to the alarm value right after it.
    if (time_load_q) begin
      edit_hr_d  = alarm_hr_q;
      edit_min_d = alarm_min_q;
    end else if (in_edit && !bus.btn_mode) begin
      if (inc_req) begin
        if (state_q == T_HOUR || state_q == A_HOUR)
          edit_hr_d = (edit_hr_q == 6'd23) ? 6'd0 : edit_hr_q + 6'd1;
        else
          edit_min_d = (edit_min_q == 7'd59) ? 7'd0 : edit_min_q + 7'd1;
      end else if (to_cnt_q == TO_W'(1)) begin
        state_d = IDLE;
      end
    end

    if (state_d != state_q)
      rpt_cnt_d = '0;

    if (state_d == IDLE)
      to_cnt_d = '0;
    else if (state_d != state_q || bus.btn_mode || inc_req)
      to_cnt_d = TO_W'(TIMEOUT_CYCLES);
    else if (to_cnt_q != '0)
      to_cnt_d = to_cnt_q - TO_W'(1);
  end

  assign bus.mode          = state_q;
  assign bus.edit_hours    = edit_hr_q;
  assign bus.edit_minutes  = edit_min_q;
  assign bus.alarm_hours   = alarm_hr_q;
  assign bus.alarm_minutes = alarm_min_q;
  assign bus.time_load     = time_load_q;
  assign bus.alarm_load    = alarm_load_q;

endmodule

// File: tb/tb_clock_set_controller.sv
module tb_clock_set_controller;
  localparam int TO = 50;
  localparam int RD = 8;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miss    = 0;

  clock_set_controller_if bus_if ();

  clock_set_controller #(
    .TIMEOUT_CYCLES (TO),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Reference model: mode as a number, fields as integers, press age and
  // idle time as plain up-counts.
  int m_state, m_eh, m_em, m_ah, m_am;
  bit m_tl, m_al, m_prev, m_hold;
  int m_k, m_idle;

  task automatic model_edge(input bit r, input bit bm, input bit bi, input int ch, input int cm);
    bit inc;
    bit tl_was;
    int ns;
    if (r) begin
      m_state = 0; m_eh = 0; m_em = 0; m_ah = 0; m_am = 0;
      m_tl = 0; m_al = 0; m_prev = 0; m_hold = 0; m_k = 0; m_idle = 0;
      return;
    end
    inc    = 0;
    tl_was = m_tl;
    ns     = m_state;
    if (m_state != 0 && bi) begin
      if (!m_prev) begin
        m_hold = 1;
        m_k    = 0;
      end else if (m_hold) begin
        m_k++;
      end
      if (m_hold && (m_k == 0 || (m_k >= RD && (m_k - RD) % RP == 0))) inc = 1;
    end else begin
      m_hold = 0;
    end
    m_prev = bi;
    m_tl = 0;
    m_al = 0;
    if (bm) begin
      case (m_state)
        0: begin ns = 1; m_eh = ch; m_em = cm; end
        1: ns = 2;
        2: begin ns = 3; m_tl = 1; end
        3: ns = 4;
        default: begin ns = 0; m_ah = m_eh; m_am = m_em; m_al = 1; end
      endcase
    end
    if (tl_was) begin
      m_eh = m_ah;
      m_em = m_am;
    end else if (m_state != 0 && !bm && inc) begin
      if (m_state == 1 || m_state == 3) m_eh = (m_eh + 1) % 24;
      else                              m_em = (m_em + 1) % 60;
    end
    if (m_state != 0) begin
      if (bm || inc) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle >= TO) ns = 0;
      end
    end
    if (ns != m_state) begin
      m_hold = 0;
      m_idle = 0;
    end
    m_state = ns;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [30:0] obs, exp;
    @(posedge clk);
    model_edge(rst, bus_if.btn_mode, bus_if.btn_inc, int'(bus_if.curr_hours), int'(bus_if.curr_minutes));
    #1;
    exp = {3'(m_state), 6'(m_eh), 7'(m_em), 6'(m_ah), 7'(m_am), m_tl, m_al};
    obs = {bus_if.mode, bus_if.edit_hours, bus_if.edit_minutes, bus_if.alarm_hours,
           bus_if.alarm_minutes, bus_if.time_load, bus_if.alarm_load};
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL model t=%0t: observed %h expected %h", $time, obs, exp);
    end
    vectors++;
    assert (!(bus_if.time_load && bus_if.alarm_load)) else begin
      miss++;
      $error("FAIL both_loads t=%0t: observed tl=%0b al=%0b expected not both", $time,
             bus_if.time_load, bus_if.alarm_load);
    end
  endtask

  task automatic pulse_mode();
    bus_if.btn_mode = 1'b1;
    tick();
    bus_if.btn_mode = 1'b0;
  endtask

  task automatic press();
    bus_if.btn_inc = 1'b1;
    tick();
    bus_if.btn_inc = 1'b0;
    tick();
  endtask

  initial begin
    int exp_min;
    bus_if.btn_mode     = 1'b0;
    bus_if.btn_inc      = 1'b0;
    bus_if.curr_hours   = 6'd0;
    bus_if.curr_minutes = 7'd0;

    // reset state
    tick(); tick();
    check("rst_mode", bus_if.mode, 0);
    check("rst_edit", {bus_if.edit_hours, bus_if.edit_minutes}, 0);
    check("rst_alarm", {bus_if.alarm_hours, bus_if.alarm_minutes}, 0);
    check("rst_loads", {bus_if.time_load, bus_if.alarm_load}, 0);
    rst = 1'b0;
    tick();

    // capture 13:45, walk to the alarm edit
    bus_if.curr_hours = 6'd13; bus_if.curr_minutes = 7'd45;
    pulse_mode();
    check("capture_mode", bus_if.mode, 1);
    check("capture_h", bus_if.edit_hours, 13);
    check("capture_m", bus_if.edit_minutes, 45);
    pulse_mode();
    check("tmin_mode", bus_if.mode, 2);
    pulse_mode();
    check("tload_strobe", bus_if.time_load, 1);
    check("tload_edit", {bus_if.edit_hours, bus_if.edit_minutes}, {6'd13, 7'd45});
    check("tload_mode", bus_if.mode, 3);
    tick();
    check("tload_end", bus_if.time_load, 0);
    check("reload_edit", {bus_if.edit_hours, bus_if.edit_minutes}, 0);
    pulse_mode();
    pulse_mode();
    check("commit0_al", bus_if.alarm_load, 1);
    check("commit0_mode", bus_if.mode, 0);
    tick();
    check("commit0_al_end", bus_if.alarm_load, 0);

    // wraps, no carry between fields
    bus_if.curr_hours = 6'd22; bus_if.curr_minutes = 7'd58;
    pulse_mode();
    press(); check("hr_23", bus_if.edit_hours, 23);
    press(); check("hr_wrap0", bus_if.edit_hours, 0);
    press(); check("hr_1", bus_if.edit_hours, 1);
    pulse_mode();
    press(); check("min_59", bus_if.edit_minutes, 59);
    press(); check("min_wrap0", bus_if.edit_minutes, 0);
    check("hr_no_carry", bus_if.edit_hours, 1);

    // timeout from T_MIN: one idle cycle already elapsed inside press()
    repeat (48) tick();
    check("to_49_mode", bus_if.mode, 2);
    tick();
    check("to_50_mode", bus_if.mode, 0);
    check("to_no_tload", bus_if.time_load, 0);
    check("to_alarm", {bus_if.alarm_hours, bus_if.alarm_minutes}, 0);

    // auto-repeat in A_MIN: increments at +1, +9, +12, +15, +18, +21
    repeat (4) pulse_mode();
    check("amin_mode", bus_if.mode, 4);
    check("amin_min0", bus_if.edit_minutes, 0);
    bus_if.btn_inc = 1'b1;
    exp_min = 0;
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (k == 1 || k == 9 || k == 12 || k == 15 || k == 18 || k == 21) exp_min++;
      check($sformatf("rpt_edge%0d", k), bus_if.edit_minutes, exp_min);
    end
    bus_if.btn_inc = 1'b0;
    repeat (3) tick();
    check("rpt_total", bus_if.edit_minutes, 6);

    // alarm 06:30, commit with a coincident increment
    pulse_mode();
    repeat (3) pulse_mode();
    tick();
    check("ahour_edit", {bus_if.edit_hours, bus_if.edit_minutes}, {6'd0, 7'd6});
    repeat (6) press();
    check("ahour_6", bus_if.edit_hours, 6);
    pulse_mode();
    repeat (24) press();
    check("amin_30", bus_if.edit_minutes, 30);
    bus_if.btn_mode = 1'b1; bus_if.btn_inc = 1'b1;
    tick();
    check("coinc_al", bus_if.alarm_load, 1);
    check("coinc_alarm", {bus_if.alarm_hours, bus_if.alarm_minutes}, {6'd6, 7'd30});
    check("coinc_mode", bus_if.mode, 0);
    bus_if.btn_mode = 1'b0; bus_if.btn_inc = 1'b0;
    tick();
    check("coinc_al_once", bus_if.alarm_load, 0);
    check("coinc_alarm_hold", {bus_if.alarm_hours, bus_if.alarm_minutes}, {6'd6, 7'd30});

    // reset during A_HOUR beats simultaneous buttons
    repeat (3) pulse_mode();
    tick();
    check("pre_rst_mode", bus_if.mode, 3);
    rst = 1'b1; bus_if.btn_mode = 1'b1; bus_if.btn_inc = 1'b1;
    tick();
    check("midrst_mode", bus_if.mode, 0);
    check("midrst_fields", {bus_if.edit_hours, bus_if.edit_minutes,
                            bus_if.alarm_hours, bus_if.alarm_minutes}, 0);
    check("midrst_loads", {bus_if.time_load, bus_if.alarm_load}, 0);
    rst = 1'b0; bus_if.btn_mode = 1'b0; bus_if.btn_inc = 1'b0;
    tick();
    check("postrst_mode", bus_if.mode, 0);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst                 = ($urandom_range(499, 0) == 0);
      bus_if.btn_mode     = ($urandom_range(24, 0) == 0);
      if ($urandom_range(5, 0) == 0) bus_if.btn_inc = ~bus_if.btn_inc;
      bus_if.curr_hours   = 6'($urandom_range(23, 0));
      bus_if.curr_minutes = 7'($urandom_range(59, 0));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
